run_mode_scanner: RTL and testbench
===================================

// Module: run_mode_scanner
// PURPOSE
//   Upstream run-mode stage for the JPEG-LS encoder. Counts run pixels and tracks RUNindex and J[RUNindex].
//   Emits one registered token per run event (HIT, INTERRUPT, EOL) to the run encoders, including
//   Encode_Pixel_With_Hit. The token carries J, run_length and the token kind, so the encoders stay combinational.
// PARAMETERS
//   J_length         `J_length         width of J value (J <= 15)
//   runcount_length  `runcount_length  width of run counter / run_length output
//   runindex_length  5                 width of RUNindex (0..31)
// PORTS
//   clk            in   1                clock, rising edge
//   reset          in   1                synchronous, active-high
//   in_valid       in   1                pixel available
//   in_ready       out  1                pixel accepted when in_valid & in_ready
//   in_run         in   1                pixel is coded in run mode (context selected run)
//   in_match       in   1                |Ix - Ra| <= NEAR
//   in_eol         in   1                pixel is last in line
//   out_valid      out  1                token valid
//   out_ready      in   1                downstream accepts token
//   out_kind       out  2                0=NONE 1=HIT 2=INTERRUPT 3=EOL
//   out_J          out  J_length         J[RUNindex] at the event
//   out_run_length out  runcount_length  residual run count (INTERRUPT/EOL), 0 for HIT
//   run_index      out  runindex_length  current RUNindex (for context / interrupt coding)
// BEHAVIOUR
//   - Reset: state=IDLE, cnt=0, RUNindex=0, out_valid=0, out_kind=0, out_J=0, out_run_length=0; in_ready=1 in the cycle after reset.
//   - in_ready = !out_valid | out_ready. Hold token stable while out_valid & !out_ready.
//   - Pixels with in_run=0 are accepted without producing a token or changing state.
//   - Run accept with in_match=1: cnt' = cnt+1.
//       If cnt' == (1<<J[RUNindex]): emit HIT with out_J=J[RUNindex]; cnt<=0; RUNindex<=min(RUNindex+1,31).
//       Else if in_eol and cnt'>0: emit EOL with out_run_length=cnt'; cnt<=0; RUNindex unchanged.
//       Else: no token.
//   - Run accept with in_match=0: emit INTERRUPT with out_run_length=cnt and out_J=J[RUNindex] (pre-decrement).
//       Then cnt<=0 and RUNindex<=max(RUNindex-1,0).
//   - HIT and EOL in the same pixel: emit HIT only. No EOL token follows; the run ended on the hit boundary.
//   - Latency: token out_valid is asserted the cycle after the accepting edge.
//   - FSM: IDLE (no open run) -> RUN on the first run-match accept. RUN -> IDLE on INTERRUPT or EOL. HIT stays in RUN.
//   - cnt never exceeds 1<<J; with J <= 15 it fits within runcount_length >= 16 without wrap.
//   - RUNindex persists across lines and resets only on reset.
// CONFIGURATION
//   RUN_STATS_EN defined: adds ports hit_count and interrupt_count (out, 16 each).
//     Each increments on the token handshake of its kind (out_valid & out_ready). Saturates at 16'hFFFF; reset to 0.
//   RUN_STATS_EN undefined: ports and counters are absent; all other behaviour is identical.
// STRUCTURE
//   Shared package / Parameterize_JPEGLS.v holds:
//     - token kind constants RUN_TOK_NONE/HIT/INTERRUPT/EOL
//     - J table {0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,4,4,5,5,6,6,7,7,8,9,10,11,12,13,14,15}
//     - width macros
//   Sub-module jpegls_j_table: combinational RUNindex -> J lookup.
// TESTING
//   1. reset mid-run (cnt=3, RUNindex=5) -> next cycle out_valid=0, run_index=0; a new run restarts from cnt=0.
//   2. RUNindex=0, 1 match pixel -> HIT token J=0 run_length=0; run_index becomes 1.
//   3. RUNindex=4 (J=1), 1 match then 1 non-match -> INTERRUPT J=1 run_length=1; run_index becomes 3.
//   4. RUNindex=8 (J=2), 3 matches, last with in_eol -> EOL run_length=3; run_index stays 8.
//   5. RUNindex=8, 4 matches, 4th with in_eol -> HIT only, no EOL token; run_index becomes 9.
//   6. out_ready=0 for 5 cycles during a pending HIT -> in_ready=0 and token stable; with RUN_STATS_EN, hit_count +1 on release.

Source files
------------

// File: rtl/run_mode_scanner_pkg.sv
// run_mode_scanner_pkg: shared constants for the JPEG-LS run-mode stage.
// Holds run token kinds, the J[RUNindex] table, datapath widths and the
// registered token layout used between the scanner and the run encoders.
package run_mode_scanner_pkg;

  // Datapath widths (J <= 15, so a 16-bit run counter never wraps)
  localparam int J_LENGTH        = 4;
  localparam int RUNCOUNT_LENGTH = 16;
  localparam int RUNINDEX_LENGTH = 5;
  localparam int STATS_W         = 16;

  // Token kinds presented to the run encoders
  typedef enum logic [1:0] {
    RUN_TOK_NONE      = 2'd0,
    RUN_TOK_HIT       = 2'd1,
    RUN_TOK_INTERRUPT = 2'd2,
    RUN_TOK_EOL       = 2'd3
  } run_tok_e;

  // Scanner state: whether a run is currently open
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } scan_state_e;

  // Registered token handed downstream
  typedef struct packed {
    run_tok_e                   kind;
    logic [J_LENGTH-1:0]        j;
    logic [RUNCOUNT_LENGTH-1:0] run_length;
  } run_tok_t;

  // J[RUNindex] as defined by the JPEG-LS standard
  localparam logic [J_LENGTH-1:0] J_TABLE [0:31] = '{
    4'd0,  4'd0,  4'd0,  4'd0,  4'd1,  4'd1,  4'd1,  4'd1,
    4'd2,  4'd2,  4'd2,  4'd2,  4'd3,  4'd3,  4'd3,  4'd3,
    4'd4,  4'd4,  4'd5,  4'd5,  4'd6,  4'd6,  4'd7,  4'd7,
    4'd8,  4'd9,  4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15
  };

  // Run length at which a HIT is declared: 1 << J
  function automatic logic [RUNCOUNT_LENGTH-1:0] run_limit(input logic [J_LENGTH-1:0] j);
    run_limit    = '0;
    run_limit[j] = 1'b1;
  endfunction

endpackage

// File: rtl/run_mode_scanner_j_table.sv
// jpegls_j_table: combinational RUNindex -> J[RUNindex] lookup.
module jpegls_j_table
  import run_mode_scanner_pkg::*;
(
  input  logic [RUNINDEX_LENGTH-1:0] run_index,
  output logic [J_LENGTH-1:0]        j
);

  // Direct table read; RUNindex covers all 32 entries
  assign j = J_TABLE[run_index];

endmodule

// File: rtl/run_mode_scanner.sv
// run_mode_scanner: JPEG-LS run-mode front end. Counts run pixels, tracks
// RUNindex and emits one registered token (HIT / INTERRUPT / EOL) per run
// event so the downstream run encoders can stay purely combinational.
// Optional feature macro: RUN_STATS_EN adds saturating hit / interrupt
// handshake counters on ports hit_count and interrupt_count.
module run_mode_scanner
  import run_mode_scanner_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_run,
  input  logic                       in_match,
  input  logic                       in_eol,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [1:0]                 out_kind,
  output logic [J_LENGTH-1:0]        out_J,
  output logic [RUNCOUNT_LENGTH-1:0] out_run_length,
  output logic [RUNINDEX_LENGTH-1:0] run_index
`ifdef RUN_STATS_EN
  ,
  output logic [STATS_W-1:0]         hit_count,
  output logic [STATS_W-1:0]         interrupt_count
`endif
);

  scan_state_e                state, nxt_state;
  logic [RUNCOUNT_LENGTH-1:0] cnt, nxt_cnt, cnt_inc;
  logic [RUNINDEX_LENGTH-1:0] run_idx, nxt_idx, idx_up, idx_dn;
  logic [J_LENGTH-1:0]        cur_j;
  run_tok_t                   tok_q, nxt_tok;
  logic                       emit;
  logic                       accept;

  jpegls_j_table u_j_table (
    .run_index (run_idx),
    .j         (cur_j)
  );

  // A token slot frees up either when empty or when being drained this cycle,
  // so a new token can be loaded on the same edge the old one is taken.
  assign in_ready = !out_valid | out_ready;
  assign accept   = in_valid & in_ready;

  assign cnt_inc = cnt + RUNCOUNT_LENGTH'(1);
  assign idx_up  = (run_idx == '1) ? run_idx : run_idx + RUNINDEX_LENGTH'(1);
  assign idx_dn  = (run_idx == '0) ? run_idx : run_idx - RUNINDEX_LENGTH'(1);

  // Next-state / token decode for one accepted run pixel
  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    nxt_idx   = run_idx;
    emit      = 1'b0;
    nxt_tok   = '{kind: RUN_TOK_NONE, j: '0, run_length: '0};
    if (accept && in_run) begin
      if (in_match) begin
        if (cnt_inc == run_limit(cur_j)) begin
          // Hit boundary wins over end-of-line: the run closes exactly here
          emit      = 1'b1;
          nxt_tok   = '{kind: RUN_TOK_HIT, j: cur_j, run_length: '0};
          nxt_cnt   = '0;
          nxt_idx   = idx_up;
          nxt_state = ST_RUN;
        end else if (in_eol) begin
          // cnt_inc is at least 1 here, so the EOL always carries a residual
          emit      = 1'b1;
          nxt_tok   = '{kind: RUN_TOK_EOL, j: cur_j, run_length: cnt_inc};
          nxt_cnt   = '0;
          nxt_state = ST_IDLE;
        end else begin
          nxt_cnt   = cnt_inc;
          nxt_state = ST_RUN;
        end
      end else begin
        // Interrupt reports J before RUNindex is decremented
        emit      = 1'b1;
        nxt_tok   = '{kind: RUN_TOK_INTERRUPT, j: cur_j, run_length: cnt};
        nxt_cnt   = '0;
        nxt_idx   = idx_dn;
        nxt_state = ST_IDLE;
      end
    end
  end

  // Run state, counters and the registered output token
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      run_idx   <= '0;
      out_valid <= 1'b0;
      tok_q     <= '0;
    end else begin
      state   <= nxt_state;
      cnt     <= nxt_cnt;
      run_idx <= nxt_idx;
      if (emit) begin
        out_valid <= 1'b1;
        tok_q     <= nxt_tok;
      end else if (out_ready) begin
        out_valid <= 1'b0;
        tok_q     <= '0;
      end
    end
  end

  assign out_kind       = tok_q.kind;
  assign out_J          = tok_q.j;
  assign out_run_length = tok_q.run_length;
  assign run_index      = run_idx;

`ifdef RUN_STATS_EN
  logic tok_hs;
  assign tok_hs = out_valid & out_ready;

  // Saturating per-kind counters, stepped on the downstream handshake
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_count       <= '0;
      interrupt_count <= '0;
    end else if (tok_hs) begin
      if (tok_q.kind == RUN_TOK_HIT && hit_count != '1)
        hit_count <= hit_count + STATS_W'(1);
      if (tok_q.kind == RUN_TOK_INTERRUPT && interrupt_count != '1)
        interrupt_count <= interrupt_count + STATS_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_run_mode_scanner.sv
// tb_run_mode_scanner: directed bench for run_mode_scanner.
module tb_run_mode_scanner;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, in_run, in_match, in_eol;
  logic        out_valid, out_ready;
  logic [1:0]  out_kind;
  logic [3:0]  out_J;
  logic [15:0] out_run_length;
  logic [4:0]  run_index;
`ifdef RUN_STATS_EN
  logic [15:0] hit_count, interrupt_count;
`endif

  int n_vec = 0;
  int n_err = 0;
  int exp_hits = 0;
  int exp_ints = 0;

  run_mode_scanner dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_run         (in_run),
    .in_match       (in_match),
    .in_eol         (in_eol),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_kind       (out_kind),
    .out_J          (out_J),
    .out_run_length (out_run_length),
    .run_index      (run_index)
`ifdef RUN_STATS_EN
    ,
    .hit_count      (hit_count),
    .interrupt_count(interrupt_count)
`endif
  );

  always #5 clk = ~clk;

  // One pixel presented for one edge; outputs are then 1ns past that edge
  task automatic pix(input logic run, input logic match, input logic eol);
    in_valid = 1'b1; in_run = run; in_match = match; in_eol = eol;
    @(posedge clk); #1;
    in_valid = 1'b0; in_run = 1'b0; in_match = 1'b0; in_eol = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset;
    reset = 1'b1; out_ready = 1'b1;
    in_valid = 1'b0; in_run = 1'b0; in_match = 1'b0; in_eol = 1'b0;
    idle(2);
    reset = 1'b0;
    n_vec++; if ({out_valid, out_kind, out_J, out_run_length} !== 23'd0) begin n_err++; $display("FAIL reset_token got %h want 0", {out_valid, out_kind, out_J, out_run_length}); end
    n_vec++; if (run_index !== 5'd0) begin n_err++; $display("FAIL reset_index got %0d want 0", run_index); end
    idle(1);
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
`ifdef RUN_STATS_EN
    n_vec++; if ({hit_count, interrupt_count} !== 32'd0) begin n_err++; $display("FAIL reset_stats got %h want 0", {hit_count, interrupt_count}); end
`endif
  endtask

  // RUNindex 0..3 all have J=0: each single match is a HIT
  task automatic test_hit;
    pix(1, 1, 0);
    n_vec++; if ({out_valid, out_kind, out_J, out_run_length} !== {1'b1, 2'd1, 4'd0, 16'd0}) begin n_err++; $display("FAIL hit_token got %h want %h", {out_valid, out_kind, out_J, out_run_length}, {1'b1, 2'd1, 4'd0, 16'd0}); end
    n_vec++; if (run_index !== 5'd1) begin n_err++; $display("FAIL hit_index got %0d want 1", run_index); end
    exp_hits++;
    idle(1);
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL hit_drain got %b want 0", out_valid); end
  endtask

  // Consecutive pixels, each producing a HIT on back-to-back cycles
  task automatic test_back_to_back;
    for (int i = 0; i < 3; i++) begin
      pix(1, 1, 0);
      n_vec++; if ({out_valid, out_kind, out_J} !== {1'b1, 2'd1, 4'd0}) begin n_err++; $display("FAIL b2b_token%0d got %h want %h", i, {out_valid, out_kind, out_J}, {1'b1, 2'd1, 4'd0}); end
      n_vec++; if (run_index !== 5'(i + 2)) begin n_err++; $display("FAIL b2b_index%0d got %0d want %0d", i, run_index, i + 2); end
      exp_hits++;
    end
  endtask

  // RUNindex 4 (J=1): one match, then a break
  task automatic test_interrupt;
    pix(1, 1, 0);
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL int_pre got %b want 0", out_valid); end
    pix(1, 0, 0);
    n_vec++; if ({out_valid, out_kind, out_J, out_run_length} !== {1'b1, 2'd2, 4'd1, 16'd1}) begin n_err++; $display("FAIL int_token got %h want %h", {out_valid, out_kind, out_J, out_run_length}, {1'b1, 2'd2, 4'd1, 16'd1}); end
    n_vec++; if (run_index !== 5'd3) begin n_err++; $display("FAIL int_index got %0d want 3", run_index); end
    exp_ints++;
    // Climb back: idx3 needs 1 match, idx4..7 need 2 each
    pix(1, 1, 0);
    for (int i = 0; i < 4; i++) begin pix(1, 1, 0); pix(1, 1, 0); end
    exp_hits += 5;
    n_vec++; if (run_index !== 5'd8) begin n_err++; $display("FAIL climb_index got %0d want 8", run_index); end
  endtask

  // RUNindex 8 (J=2): 3 matches with a non-run pixel in between, last ends line
  task automatic test_eol;
    idle(1);
    pix(1, 1, 0);
    pix(1, 1, 0);
    pix(0, 1, 1);
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL nonrun_token got %b want 0", out_valid); end
    n_vec++; if (run_index !== 5'd8) begin n_err++; $display("FAIL nonrun_index got %0d want 8", run_index); end
    pix(1, 1, 1);
    n_vec++; if ({out_valid, out_kind, out_J, out_run_length} !== {1'b1, 2'd3, 4'd2, 16'd3}) begin n_err++; $display("FAIL eol_token got %h want %h", {out_valid, out_kind, out_J, out_run_length}, {1'b1, 2'd3, 4'd2, 16'd3}); end
    n_vec++; if (run_index !== 5'd8) begin n_err++; $display("FAIL eol_index got %0d want 8", run_index); end
  endtask

  // RUNindex 8: the 4th match hits and ends the line at once
  task automatic test_hit_eol;
    pix(1, 1, 0); pix(1, 1, 0); pix(1, 1, 0);
    pix(1, 1, 1);
    n_vec++; if ({out_valid, out_kind, out_J, out_run_length} !== {1'b1, 2'd1, 4'd2, 16'd0}) begin n_err++; $display("FAIL hiteol_token got %h want %h", {out_valid, out_kind, out_J, out_run_length}, {1'b1, 2'd1, 4'd2, 16'd0}); end
    n_vec++; if (run_index !== 5'd9) begin n_err++; $display("FAIL hiteol_index got %0d want 9", run_index); end
    exp_hits++;
    idle(1);
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL hiteol_no_eol got %b want 0", out_valid); end
  endtask

  // RUNindex 9 (J=2): HIT held under 5 cycles of backpressure
  task automatic test_backpressure;
    out_ready = 1'b0;
    pix(1, 1, 0); pix(1, 1, 0); pix(1, 1, 0);
    pix(1, 1, 0);
    n_vec++; if ({out_valid, out_kind, out_J, out_run_length} !== {1'b1, 2'd1, 4'd2, 16'd0}) begin n_err++; $display("FAIL bp_token got %h want %h", {out_valid, out_kind, out_J, out_run_length}, {1'b1, 2'd1, 4'd2, 16'd0}); end
    for (int i = 0; i < 5; i++) begin
      idle(1);
      n_vec++; if ({in_ready, out_valid, out_kind, out_J, out_run_length} !== {1'b0, 1'b1, 2'd1, 4'd2, 16'd0}) begin n_err++; $display("FAIL bp_hold%0d got %h want %h", i, {in_ready, out_valid, out_kind, out_J, out_run_length}, {1'b0, 1'b1, 2'd1, 4'd2, 16'd0}); end
    end
    out_ready = 1'b1;
    #1;
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_ready got %b want 1", in_ready); end
    exp_hits++;
    idle(1);
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_drain got %b want 0", out_valid); end
    n_vec++; if (run_index !== 5'd10) begin n_err++; $display("FAIL bp_index got %0d want 10", run_index); end
`ifdef RUN_STATS_EN
    n_vec++; if (hit_count !== 16'(exp_hits)) begin n_err++; $display("FAIL stats_hits got %0d want %0d", hit_count, exp_hits); end
    n_vec++; if (interrupt_count !== 16'(exp_ints)) begin n_err++; $display("FAIL stats_ints got %0d want %0d", interrupt_count, exp_ints); end
`endif
  endtask

  // RUNindex 10 (J=2): 3 matches leave cnt=3, then reset mid-run
  task automatic test_reset_mid_run;
    pix(1, 1, 0); pix(1, 1, 0); pix(1, 1, 0);
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL midrun_pre got %b want 0", out_valid); end
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    n_vec++; if ({out_valid, run_index} !== 6'd0) begin n_err++; $display("FAIL midrun_reset got %h want 0", {out_valid, run_index}); end
`ifdef RUN_STATS_EN
    n_vec++; if ({hit_count, interrupt_count} !== 32'd0) begin n_err++; $display("FAIL midrun_stats got %h want 0", {hit_count, interrupt_count}); end
`endif
    // A stale count would overshoot the J=0 limit and miss this HIT
    pix(1, 1, 0);
    n_vec++; if ({out_valid, out_kind, out_J, out_run_length} !== {1'b1, 2'd1, 4'd0, 16'd0}) begin n_err++; $display("FAIL midrun_restart got %h want %h", {out_valid, out_kind, out_J, out_run_length}, {1'b1, 2'd1, 4'd0, 16'd0}); end
    n_vec++; if (run_index !== 5'd1) begin n_err++; $display("FAIL midrun_index got %0d want 1", run_index); end
  endtask

  initial begin
    test_reset;
    test_hit;
    test_back_to_back;
    test_interrupt;
    test_eol;
    test_hit_eol;
    test_backpressure;
    test_reset_mid_run;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
